spi_tx_feeder: RTL
==================

Name: spi_tx_feeder

Overview:
- Upstream stage for the 16-bit SPI master: buffers words written by the system side in a small FIFO and launches one SPI frame per word.
- Drives the master's t_start/d_in pair and uses the master's read_en as its ready/done indication.
- Decouples bursty register or DMA writes from frame-serial transmission.

Parameters:
DATA_W, 16, word width; must equal the master's d_in width
DEPTH, 8, FIFO entries; power of two, minimum 2
ADDR_W, 3, log2(DEPTH); pointer width
GAP_CYCLES, 2, minimum idle cycles between frames (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on posedge
rstn  in  1  reset, asynchronous, active-high (1 = reset), despite the name
wr_en  in  1  push wr_data this cycle
wr_data  in  DATA_W  word to queue
flush  in  1  synchronous clear of queued words
full  out  1  FIFO holds DEPTH words
empty  out  1  FIFO holds no words
level  out  ADDR_W+1  number of queued words, 0..DEPTH
overflow  out  1  sticky: a push was attempted while full
busy  out  1  a frame is launched and not yet finished
read_en  in  1  master ready/done; high while master idle or unloading
t_start  out  1  one-cycle launch pulse to master
d_in  out  DATA_W  frame word to master; held stable between launches

Behaviour:
- Reset values: t_start=0, d_in=0, full=0, empty=1, level=0, overflow=0, busy=0, pointers=0, FSM=IDLE. Reset mid-frame abandons the frame; the master is not informed.
- FIFO storage:
  - Circular buffer with rd/wr pointers that wrap modulo DEPTH; level is a separate counter.
  - Push accepted iff wr_en && !full && !flush.
  - wr_en && full: word dropped, overflow<=1. overflow clears only on reset or flush.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - At full, a same-cycle pop does not admit the push; full is evaluated before the pop.
- flush:
  - Next cycle: rd=wr=0, level=0, empty=1, overflow=0.
  - Does not abort an in-flight frame; FSM and d_in are unaffected.
  - A flush coinciding with an IDLE pop makes the pop take effect, then clears the FIFO.
- FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP (GAP exists only with the optional feature):
  - IDLE: if !empty && read_en, then d_in<=mem[rd], rd++, level--, t_start<=1, busy<=1, go ISSUE.
  - ISSUE: t_start<=0, go WAIT_BUSY. t_start is high for exactly one cycle.
  - WAIT_BUSY: stay until read_en==0 (master has loaded), then go WAIT_DONE.
  - WAIT_DONE: stay until read_en==1 (master has unloaded), then busy<=0 and go IDLE (or GAP).
  - GAP: count GAP_CYCLES cycles, then go IDLE.
- Latency:
  - Push into an empty FIFO with read_en high: t_start rises 2 cycles after the push edge (1 cycle to write, 1 to launch).
  - Back-to-back frames: next t_start is no earlier than 1 cycle after read_en returns high.
- d_in changes only on a launch, so it is stable for the master's load cycle.

Optional Feature:
- Macro SPI_TX_FEEDER_GAP_EN.
- Defined: the GAP state is present and guarantees at least GAP_CYCLES cycles with cs high between frames. busy stays high through GAP.
- Undefined: WAIT_DONE goes straight to IDLE; GAP_CYCLES is ignored.

Decomposition:
- Shared package spi_pkg: DATA_W default, the FSM state encoding (3-bit localparams), and the GAP_CYCLES default. The package is reused by the master and future RX stages.
- One natural sub-module: spi_word_fifo, holding storage, pointers, level, full/empty and overflow. The feeder top contains only the FSM and the launch register.

Test Plan:
- Reset, then push 0xA5A5 with read_en=1 -> t_start pulses 1 cycle, 2 cycles after the push; d_in=0xA5A5; busy=1 until read_en falls then rises.
- Push 8 words 0x0001..0x0008 with read_en held 0 -> full=1, level=8; 9th push 0xFFFF -> dropped, overflow=1. Then toggle read_en per frame -> d_in sequence 0x0001..0x0008; empty=1 after the last.
- Push and pop in the same cycle at level=3 -> level stays 3; pointer wrap past index 7 gives correct order.
- flush asserted while in WAIT_DONE with 4 queued -> level=0, overflow=0; current frame completes; no further t_start.
- Assert rstn during WAIT_BUSY -> all outputs return to reset values asynchronously; no t_start after release until a new push.
- With SPI_TX_FEEDER_GAP_EN and GAP_CYCLES=2, two queued words -> at least 2 cycles between read_en rising and the next t_start.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: word width, feeder FSM encoding, gap default
package spi_pkg;

    // Word width shared by the SPI master, the TX feeder and future RX stages.
    localparam int DATA_W_DEF = 16;

    // Default number of idle cycles enforced between frames when the gap is built in.
    localparam int GAP_CYCLES_DEF = 2;

    // Feeder FSM encoding, kept as plain 3-bit constants so other stages can decode it.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_BUSY = ST_WAIT_BUSY,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_GAP       = ST_GAP
    } feeder_state_t;

endpackage

// File: rtl/spi_word_fifo.sv
// rtl/spi_word_fifo.sv - circular word FIFO with level counter, sticky overflow and flush
module spi_word_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    // DEPTH is a power of two equal to 2**ADDR_W, so the pointers wrap by plain overflow.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;

    logic push_ok;
    logic pop_ok;

    assign full     = (level_q == (ADDR_W+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Fullness is judged before any same-cycle pop, so a pop never makes room for a push at full.
    assign push_ok = wr_en && !full && !flush;
    assign pop_ok  = rd_en && !empty;

    // Next pointer, level and overflow; flush overrides every other update.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (wr_en && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage; contents need no reset because the level counter qualifies every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - queues words and launches one SPI master frame per word; SPI_TX_FEEDER_GAP_EN adds an inter-frame gap
module spi_tx_feeder
    import spi_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              busy,
    input  logic              read_en,
    output logic              t_start,
    output logic [DATA_W-1:0] d_in
);

    // rstn is an active-high asynchronous reset despite its name.
    feeder_state_t     state_q, state_d;
    logic              t_start_q, t_start_d;
    logic [DATA_W-1:0] d_in_q, d_in_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              launch;

`ifdef SPI_TX_FEEDER_GAP_EN
    // GAP_CYCLES is expected to be at least 1.
    localparam int GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
`else
    // GAP_CYCLES only matters when the inter-frame gap is compiled in.
    logic [31:0] unused_gap_cycles;
    assign unused_gap_cycles = 32'(GAP_CYCLES);
`endif

    // A frame launches from IDLE as soon as a word is queued and the master is ready.
    assign launch = (state_q == S_IDLE) && !fifo_empty && read_en;

    spi_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .rd_en    (launch),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (fifo_empty),
        .level    (level),
        .overflow (overflow)
    );

    assign empty   = fifo_empty;
    assign t_start = t_start_q;
    assign d_in    = d_in_q;
    assign busy    = busy_q;

    // Next-state and output decode; flush never reaches here, so an in-flight frame always completes.
    always_comb begin
        state_d   = state_q;
        t_start_d = 1'b0;
        d_in_d    = d_in_q;
        busy_d    = busy_q;
`ifdef SPI_TX_FEEDER_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    d_in_d    = fifo_rd_data;
                    t_start_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!read_en) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (read_en) begin
`ifdef SPI_TX_FEEDER_GAP_EN
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
`else
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef SPI_TX_FEEDER_GAP_EN
            S_GAP: begin
                if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and registered launch outputs; reset abandons any frame without telling the master.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= S_IDLE;
            t_start_q <= 1'b0;
            d_in_q    <= '0;
            busy_q    <= 1'b0;
`ifdef SPI_TX_FEEDER_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            t_start_q <= t_start_d;
            d_in_q    <= d_in_d;
            busy_q    <= busy_d;
`ifdef SPI_TX_FEEDER_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

endmodule
